// File: rtl/fir_pkg.sv
// Shared helpers for the reloadable-coefficient FIR: tree depth,
// accumulator width and the round/shift/saturate output stage.
package fir_pkg;

    localparam int RS_W = 64;

    function automatic int tree_levels(input int n);
        int l;
        l = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                l = i + 1;
            end
        end
        return l;
    endfunction

    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + tree_levels(taps);
    endfunction

    // Returns {sat, value}; value is already clamped into the out_w range.
    function automatic logic [RS_W:0] round_sat(
        input logic signed [RS_W-1:0] acc,
        input int                     shift,
        input int                     out_w
    );
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        logic                   s;
        r = acc;
        if (shift > 0) begin
            r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        s  = 1'b0;
        if (r > hi) begin
            r = hi;
            s = 1'b1;
        end else if (r < lo) begin
            r = lo;
            s = 1'b1;
        end
        return {s, r};
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Registered pairwise adder tree; the input vector is zero-padded to the
// next power of two so every level is a clean halving.
module fir_adder_tree
    import fir_pkg::*;
#(
    parameter int N     = 2,
    parameter int IN_W  = 32,
    parameter int OUT_W = 33
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [N*IN_W-1:0]       data_i,
    output logic                    valid_o,
    output logic signed [OUT_W-1:0] sum_o
);

    localparam int L = tree_levels(N);
    localparam int P = 1 << L;

    logic [L-1:0] vld_q;

    genvar l, j;
    generate
        for (l = 0; l <= L; l++) begin : g_lvl
            logic signed [OUT_W-1:0] s [P >> l];
            if (l == 0) begin : g_in
                for (j = 0; j < P; j++) begin : g_e
                    if (j < N) begin : g_d
                        assign s[j] = OUT_W'(signed'(data_i[j*IN_W +: IN_W]));
                    end else begin : g_z
                        assign s[j] = '0;
                    end
                end
            end else begin : g_add
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int k = 0; k < (P >> l); k++) begin
                            s[k] <= '0;
                        end
                    end else begin
                        for (int k = 0; k < (P >> l); k++) begin
                            s[k] <= g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            for (int k = 1; k < L; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign valid_o = vld_q[L-1];
    assign sum_o   = g_lvl[L].s[0];

endmodule

// File: rtl/fir_param_reload.sv
// Parametrised pipelined FIR with valid-qualified input, double-buffered
// run-time coefficient bank and rounded, saturating output.
module fir_param_reload
    import fir_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  COEF_W = 16,
    parameter int  TAPS   = 64,
    parameter int  OUT_W  = 16,
    parameter int  SHIFT  = 15,
    localparam int L      = tree_levels(TAPS),
    localparam int AW     = (L > 1) ? L : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     coef_commit,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  dout,
    output logic                     sat
);

    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);

    logic signed [DATA_W-1:0] dly_q  [TAPS];
    logic signed [COEF_W-1:0] shd_q  [TAPS];
    logic signed [COEF_W-1:0] act_q  [TAPS];
    logic signed [PW-1:0]     prod_q [TAPS];
    logic                     v0_q;
    logic                     v1_q;
    logic [TAPS*PW-1:0]       prod_flat;

    logic                     tree_v;
    logic signed [ACC_W-1:0]  tree_sum;
    logic signed [RS_W-1:0]   acc_ext;
    logic [RS_W:0]            rs;
    logic                     unused_rs;

    logic signed [OUT_W-1:0]  dout_d, dout_q;
    logic                     sat_d, sat_q;
    logic                     ov_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            v0_q <= in_valid;
            if (in_valid) begin
                dly_q[0] <= din;
                for (int i = 1; i < TAPS; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end
    end

    // Commit copies the pre-edge shadow, so a same-cycle write waits for the next commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                shd_q[i] <= '0;
                act_q[i] <= '0;
            end
        end else begin
            if (coef_commit) begin
                for (int i = 0; i < TAPS; i++) begin
                    act_q[i] <= shd_q[i];
                end
            end
            if (coef_we && (32'(coef_addr) < TAPS)) begin
                shd_q[coef_addr] <= coef_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            v1_q <= v0_q;
            for (int i = 0; i < TAPS; i++) begin
                prod_q[i] <= PW'(dly_q[i]) * PW'(act_q[i]);
            end
        end
    end

    always_comb begin
        prod_flat = '0;
        for (int i = 0; i < TAPS; i++) begin
            prod_flat[i*PW +: PW] = prod_q[i];
        end
    end

    fir_adder_tree #(
        .N     (TAPS),
        .IN_W  (PW),
        .OUT_W (ACC_W)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .valid_i (v1_q),
        .data_i  (prod_flat),
        .valid_o (tree_v),
        .sum_o   (tree_sum)
    );

    assign acc_ext   = RS_W'(tree_sum);
    assign rs        = round_sat(acc_ext, SHIFT, OUT_W);
    assign unused_rs = ^rs[RS_W-1:OUT_W];

    always_comb begin
        dout_d = rs[OUT_W-1:0];
        sat_d  = rs[RS_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
            sat_q  <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            dout_q <= dout_d;
            sat_q  <= sat_d;
            ov_q   <= tree_v;
        end
    end

    assign out_valid = ov_q;
    assign dout      = dout_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_fir_param_reload.sv
// Directed bench: impulse, bubbles, coefficient swap and reset on small
// instances; saturation and rounding on the default-parameter instance.
module tb_fir_param_reload;

    logic clk = 1'b0;
    logic rst;

    logic               iv;
    logic signed [15:0] din;
    logic               cwe;
    logic [2:0]         caddr;
    logic signed [15:0] cdata;
    logic               ccommit;

    logic               ov8, sat8, ov5, sat5;
    logic signed [39:0] dout8, dout5;

    logic               iv64;
    logic signed [15:0] din64;
    logic               cwe64;
    logic [5:0]         caddr64;
    logic signed [15:0] cdata64;
    logic               cc64;
    logic               ov64, sat64;
    logic signed [15:0] dout64;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_param_reload #(
        .DATA_W (16), .COEF_W (16), .TAPS (8), .OUT_W (40), .SHIFT (0)
    ) u8 (
        .clk (clk), .rst (rst), .in_valid (iv), .din (din),
        .coef_we (cwe), .coef_addr (caddr), .coef_data (cdata),
        .coef_commit (ccommit), .out_valid (ov8), .dout (dout8), .sat (sat8)
    );

    fir_param_reload #(
        .DATA_W (16), .COEF_W (16), .TAPS (5), .OUT_W (40), .SHIFT (0)
    ) u5 (
        .clk (clk), .rst (rst), .in_valid (iv), .din (din),
        .coef_we (cwe), .coef_addr (caddr), .coef_data (cdata),
        .coef_commit (ccommit), .out_valid (ov5), .dout (dout5), .sat (sat5)
    );

    fir_param_reload u64 (
        .clk (clk), .rst (rst), .in_valid (iv64), .din (din64),
        .coef_we (cwe64), .coef_addr (caddr64), .coef_data (cdata64),
        .coef_commit (cc64), .out_valid (ov64), .dout (dout64), .sat (sat64)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m, j, c;
        logic ev;
        rst = 1'b1;
        iv = 1'b0; din = '0; cwe = 1'b0; caddr = '0; cdata = '0; ccommit = 1'b0;
        iv64 = 1'b0; din64 = '0; cwe64 = 1'b0; caddr64 = '0; cdata64 = '0; cc64 = 1'b0;
        tick();
        tick();
        chk("rst_ov8", ov8, 0);
        chk("rst_dout8", dout8, 0);
        chk("rst_sat8", sat8, 0);
        chk("rst_ov64", ov64, 0);
        chk("rst_dout64", dout64, 0);
        chk("rst_sat64", sat64, 0);
        rst = 1'b0;

        // coef[i] = i+1; u5 ignores addresses 5..7
        for (int i = 0; i < 8; i++) begin
            cwe = 1'b1; caddr = 3'(i); cdata = 16'(i + 1);
            tick();
        end
        cwe = 1'b0; ccommit = 1'b1;
        tick();
        ccommit = 1'b0;

        for (int k = 0; k < 20; k++) begin
            iv = 1'b1; din = (k == 0) ? 16'sd1 : 16'sd0;
            tick();
            m = k + 1; j = m - 6;
            chk("imp8_v", ov8, (j >= 0) ? 1 : 0);
            chk("imp5_v", ov5, (j >= 0) ? 1 : 0);
            if (j >= 0) begin
                chk("imp8_d", dout8, (j < 8) ? j + 1 : 0);
                chk("imp8_s", sat8, 0);
                chk("imp5_d", dout5, (j < 5) ? j + 1 : 0);
            end
        end
        iv = 1'b0;
        repeat (8) tick();

        for (int k = 0; k < 36; k++) begin
            iv = ((k % 3) == 0); din = (k == 0) ? 16'sd1 : 16'sd0;
            tick();
            c = k + 1 - 6;
            ev = (c >= 0) && ((c % 3) == 0);
            chk("bub8_v", ov8, ev);
            if (ev) begin
                j = c / 3;
                chk("bub8_d", dout8, (j < 8) ? j + 1 : 0);
                chk("bub5_d", dout5, (j < 5) ? j + 1 : 0);
            end
        end
        iv = 1'b0;
        repeat (8) tick();

        // constant-1 stream: every output is the sum of one whole bank
        for (int k = 0; k < 40; k++) begin
            iv = 1'b1; din = 16'sd1;
            cwe = 1'b0; ccommit = 1'b0;
            if (k >= 10 && k <= 17) begin
                cwe = 1'b1; caddr = 3'(k - 10); cdata = 16'(10 * (k - 9));
            end
            if (k == 20) begin
                cwe = 1'b1; caddr = 3'd3; cdata = 16'sd1000; ccommit = 1'b1;
            end
            if (k == 30) ccommit = 1'b1;
            tick();
            m = k + 1;
            if (m >= 13) begin
                chk("swp8_v", ov8, 1);
                chk("swp8_d", dout8, (m <= 25) ? 36 : (m <= 35) ? 360 : 1320);
                chk("swp5_d", dout5, (m <= 25) ? 15 : (m <= 35) ? 150 : 1110);
            end
        end
        cwe = 1'b0; ccommit = 1'b0;

        rst = 1'b1;
        #1;
        chk("arst_ov8", ov8, 0);
        chk("arst_dout8", dout8, 0);
        chk("arst_sat8", sat8, 0);
        chk("arst_ov5", ov5, 0);
        iv = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            iv = 1'b1; din = (k == 0) ? 16'sd1 : 16'sd0;
            tick();
            j = k + 1 - 6;
            chk("post_v", ov8, (j >= 0) ? 1 : 0);
            if (j >= 0) begin
                chk("post_d8", dout8, 0);
                chk("post_d5", dout5, 0);
            end
        end
        iv = 1'b0;

        for (int i = 0; i < 64; i++) begin
            cwe64 = 1'b1; caddr64 = 6'(i); cdata64 = 16'sd32767;
            tick();
        end
        cwe64 = 1'b0; cc64 = 1'b1;
        tick();
        cc64 = 1'b0;

        for (int k = 0; k < 73; k++) begin
            iv64 = (k < 64); din64 = 16'sd32767;
            tick();
            m = k + 1;
            if (m == 9) begin
                chk("pos1_d", dout64, 32766);
                chk("pos1_s", sat64, 0);
            end
            if (m == 72) begin
                chk("posf_v", ov64, 1);
                chk("posf_d", dout64, 32767);
                chk("posf_s", sat64, 1);
            end
            if (m == 73) chk("posf_end", ov64, 0);
        end

        for (int k = 0; k < 73; k++) begin
            iv64 = (k < 64); din64 = 16'sh8000;
            tick();
            m = k + 1;
            if (m == 9) begin
                chk("neg1_d", dout64, 32767);
                chk("neg1_s", sat64, 1);
            end
            if (m == 72) begin
                chk("negf_d", dout64, -32768);
                chk("negf_s", sat64, 1);
            end
        end
        iv64 = 1'b0;

        for (int i = 0; i < 64; i++) begin
            cwe64 = 1'b1; caddr64 = 6'(i);
            cdata64 = (i == 0) ? 16'sd16384 : 16'sd0;
            tick();
        end
        cwe64 = 1'b0; cc64 = 1'b1;
        tick();
        cc64 = 1'b0;

        for (int k = 0; k < 12; k++) begin
            iv64 = (k < 3);
            din64 = (k == 0) ? 16'sd1 : (k == 1) ? -16'sd1 : 16'sd3;
            tick();
            m = k + 1;
            if (m == 9)  chk("rnd_p1", dout64, 1);
            if (m == 10) chk("rnd_m1", dout64, 0);
            if (m == 11) chk("rnd_p3", dout64, 2);
            if (m >= 9 && m <= 11) chk("rnd_s", sat64, 0);
            if (m == 12) chk("rnd_end", ov64, 0);
        end
        iv64 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
